// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl - transfer sequencer for the APB SPI lite master.
//
// Sits in front of the LR shift register. On an accepted start it drops chip
// select, runs SCLK from a programmable half-period divider in any CPOL/CPHA
// mode, and issues one load pulse, DATA_W-1 shift pulses and DATA_W sample
// strobes per frame. At the end it releases chip select and pulses done.
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      transfer request, only looked at while idle
//   div_i        SCLK half-period minus 1, in clk_i cycles
//   cpol_i       SCLK idle level
//   cpha_i       0: sample on leading edge, 1: sample on trailing edge
//   lsb_first_i  bit order, forwarded to the shifter as sh_rl_o
//   busy_o       high whenever a frame is in progress
//   done_o       one-cycle pulse in the frame end cycle
//   cs_n_o       chip select, active low
//   sclk_o       SPI clock
//   ld_o         one-cycle load pulse to the shifter
//   sh_en_o      one-cycle shift pulse to the shifter
//   sh_rl_o      shift direction, 1 = right / LSB first
//   sample_o     one-cycle strobe on every sampling edge
//
// All outputs are registered.

module spi_xfer_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             cpol_i,
  input  logic             cpha_i,
  input  logic             lsb_first_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             cs_n_o,
  output logic             sclk_o,
  output logic             ld_o,
  output logic             sh_en_o,
  output logic             sh_rl_o,
  output logic             sample_o
);

  // Edge counter must hold 2*DATA_W.
  localparam int EW = $clog2(2 * DATA_W) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic             cpol_r;
  logic             cpha_r;
  logic [DIV_W-1:0] cnt_r;
  logic [EW-1:0]    edge_r;

  logic             half_done_s;
  logic [EW-1:0]    edge_nxt_s;
  logic             edge_odd_s;
  logic             last_edge_s;
  logic             sample_hit_s;
  logic             shift_hit_s;

  // Decode what the next SCLK edge will be and which strobes it carries.
  always_comb begin
    half_done_s = (cnt_r == div_r);
    edge_nxt_s  = edge_r + EW'(1);
    edge_odd_s  = edge_nxt_s[0];
    last_edge_s = (edge_nxt_s == LAST_EDGE);
    // CPHA=0: sample on leading (odd) edges, shift on trailing edges except
    // the last. CPHA=1: the load presents bit 0, so shifting starts on
    // leading edge 3 and sampling happens on every trailing edge.
    sample_hit_s = cpha_r ? ~edge_odd_s : edge_odd_s;
    shift_hit_s  = cpha_r ? (edge_odd_s & (edge_nxt_s != EW'(1)))
                          : (~edge_odd_s & ~last_edge_s);
  end

  // Frame sequencer with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      div_r    <= {DIV_W{1'b0}};
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      cnt_r    <= {DIV_W{1'b0}};
      edge_r   <= {EW{1'b0}};
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      cs_n_o   <= 1'b1;
      sclk_o   <= 1'b0;
      ld_o     <= 1'b0;
      sh_en_o  <= 1'b0;
      sh_rl_o  <= 1'b0;
      sample_o <= 1'b0;
    end else begin
      // Pulse outputs default low each cycle.
      ld_o     <= 1'b0;
      sh_en_o  <= 1'b0;
      sample_o <= 1'b0;
      done_o   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r  <= {DIV_W{1'b0}};
          edge_r <= {EW{1'b0}};
          sclk_o <= cpol_i;
          if (start_i) begin
            div_r   <= div_i;
            cpol_r  <= cpol_i;
            cpha_r  <= cpha_i;
            sh_rl_o <= lsb_first_i;
            busy_o  <= 1'b1;
            cs_n_o  <= 1'b0;
            ld_o    <= 1'b1;
            state_r <= ST_SETUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        // SETUP only differs from XFER in that it produces edge 1.
        ST_SETUP, ST_XFER: begin
          if (half_done_s) begin
            cnt_r    <= {DIV_W{1'b0}};
            edge_r   <= edge_nxt_s;
            sclk_o   <= ~sclk_o;
            sample_o <= sample_hit_s;
            sh_en_o  <= shift_hit_s;
            state_r  <= last_edge_s ? ST_HOLD : ST_XFER;
          end else begin
            cnt_r <= cnt_r + DIV_W'(1);
          end
        end
        ST_HOLD: begin
          if (half_done_s) begin
            cnt_r   <= {DIV_W{1'b0}};
            edge_r  <= {EW{1'b0}};
            busy_o  <= 1'b0;
            cs_n_o  <= 1'b1;
            done_o  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + DIV_W'(1);
          end
        end
        default: begin
          cnt_r   <= {DIV_W{1'b0}};
          edge_r  <= {EW{1'b0}};
          busy_o  <= 1'b0;
          cs_n_o  <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Testbench for spi_xfer_ctrl: directed scenarios followed by random traffic.
// A reference model, running on each rising edge, decides which starts are
// accepted and pushes the expected pulse timeline of every accepted frame
// into a queue. A monitor on the falling edge pops that queue and compares
// the pulse outputs, and checks the level outputs against the frame window.

module tb_spi_xfer_ctrl;
  localparam int W  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [DW-1:0] div_i;
  logic          cpol_i;
  logic          cpha_i;
  logic          lsb_first_i;
  logic          busy_o, done_o, cs_n_o, sclk_o, ld_o, sh_en_o, sh_rl_o, sample_o;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.DATA_W(W), .DIV_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .div_i(div_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_first_i(lsb_first_i),
    .busy_o(busy_o), .done_o(done_o), .cs_n_o(cs_n_o), .sclk_o(sclk_o),
    .ld_o(ld_o), .sh_en_o(sh_en_o), .sh_rl_o(sh_rl_o), .sample_o(sample_o)
  );

  // Pulse kinds, used as bit positions in {ld, sample, sh_en, done}.
  localparam int K_DONE = 0;
  localparam int K_SH   = 1;
  localparam int K_SMP  = 2;
  localparam int K_LD   = 3;

  typedef struct {
    int t;
    int kind;
  } ev_t;

  ev_t ev_q[$];

  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  bit  chk_en = 1'b0;

  // Model state for the frame in flight (or the last one).
  bit  f_act = 1'b0;
  int  fa, fd, fstep;
  bit  fcpol, flsb;
  bit  last_lsb = 1'b0;
  int  next_ok = 0;
  int  rst_cyc = -1;
  bit  idle_sclk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: accept/reject starts and predict the frame timeline.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_i) begin
        ev_q.delete();
        f_act    = 1'b0;
        next_ok  = cyc + 1;
        rst_cyc  = cyc + 1;
        last_lsb = 1'b0;
      end else if (start_i && cyc >= next_ok) begin
        ev_t e;
        f_act = 1'b1;
        fstep = int'(div_i) + 1;
        fa    = cyc + 1;
        fd    = cyc + 1 + (2 * W + 1) * fstep;
        fcpol = cpol_i;
        flsb  = lsb_first_i;
        last_lsb = lsb_first_i;
        next_ok  = fd;
        e.t = fa; e.kind = K_LD; ev_q.push_back(e);
        for (int k = 1; k <= 2 * W; k++) begin
          bit odd;
          bit smp;
          bit sh;
          odd = (k % 2) == 1;
          if (cpha_i == 1'b0) begin
            smp = odd;
            sh  = !odd && (k < 2 * W);
          end else begin
            smp = !odd;
            sh  = odd && (k >= 3);
          end
          e.t = fa + k * fstep;
          if (smp) begin e.kind = K_SMP; ev_q.push_back(e); end
          if (sh)  begin e.kind = K_SH;  ev_q.push_back(e); end
        end
        e.t = fd; e.kind = K_DONE; ev_q.push_back(e);
      end
      idle_sclk = cpol_i;
      cyc++;
    end
  end

  // Monitor: compare levels and pulses once per cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        int  m;
        bit  x_cs, x_busy, x_sclk, x_rl;
        logic [3:0] x_pulse;
        m = cyc;
        if (m == rst_cyc) begin
          x_cs = 1'b1; x_busy = 1'b0; x_sclk = 1'b0; x_rl = 1'b0;
        end else if (f_act && m >= fa && m <= fd) begin
          int e;
          e = (m - fa) / fstep;
          if (e > 2 * W) e = 2 * W;
          x_cs   = (m == fd);
          x_busy = (m != fd);
          x_sclk = fcpol ^ e[0];
          x_rl   = flsb;
        end else begin
          x_cs = 1'b1; x_busy = 1'b0; x_sclk = idle_sclk; x_rl = last_lsb;
        end
        check("levels{cs_n,busy,sclk,sh_rl}", {28'd0, cs_n_o, busy_o, sclk_o, sh_rl_o},
              {28'd0, x_cs, x_busy, x_sclk, x_rl});
        x_pulse = 4'd0;
        while (ev_q.size() > 0 && ev_q[0].t <= m) begin
          if (ev_q[0].t == m) x_pulse[ev_q[0].kind] = 1'b1;
          else check("missed_pulse_time", m, ev_q[0].t);
          void'(ev_q.pop_front());
        end
        check("pulses{ld,sample,sh_en,done}", {28'd0, ld_o, sample_o, sh_en_o, done_o},
              {28'd0, x_pulse});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus.
  initial begin
    rst_i = 1'b1; start_i = 1'b0; div_i = '0;
    cpol_i = 1'b0; cpha_i = 1'b0; lsb_first_i = 1'b0;
    step(3);
    rst_i = 1'b0;
    chk_en = 1'b1;
    step(2);

    // Mode 0, div=1, MSB first.
    div_i = 8'd1; cpol_i = 1'b0; cpha_i = 1'b0; lsb_first_i = 1'b0;
    start_i = 1'b1; step(1); start_i = 1'b0; step(40);

    // Mode 3, div=0.
    cpol_i = 1'b1; cpha_i = 1'b1; div_i = 8'd0;
    step(3);
    start_i = 1'b1; step(1); start_i = 1'b0; step(22);

    // Config latching with start held high through the frame.
    cpol_i = 1'b0; cpha_i = 1'b0; div_i = 8'd1;
    start_i = 1'b1; step(10);
    div_i = 8'd5; cpol_i = 1'b1; step(25);
    start_i = 1'b0; step(110);

    // Back-to-back frames.
    div_i = 8'd0; cpol_i = 1'b0; cpha_i = 1'b1;
    start_i = 1'b1; step(60); start_i = 1'b0; step(20);

    // Reset after edge 5.
    div_i = 8'd1; cpha_i = 1'b0;
    start_i = 1'b1; step(1); start_i = 1'b0; step(11);
    rst_i = 1'b1; step(1); rst_i = 1'b0; step(10);

    // Simultaneous reset and start: the start is dropped.
    rst_i = 1'b1; start_i = 1'b1; step(1);
    rst_i = 1'b0; start_i = 1'b0; step(5);

    // LSB first, cpha=0, div=3.
    lsb_first_i = 1'b1; div_i = 8'd3; cpha_i = 1'b0; cpol_i = 1'b0;
    start_i = 1'b1; step(1); start_i = 1'b0; step(75);

    // Random traffic with config changes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      start_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        div_i       = DW'($urandom_range(0, 3));
        cpol_i      = $urandom_range(0, 1) == 1;
        cpha_i      = $urandom_range(0, 1) == 1;
        lsb_first_i = $urandom_range(0, 1) == 1;
      end
      rst_i = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst_i = 1'b0; start_i = 1'b0;
    step(120);
    check("pending_events_drained", ev_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
